counter_ctrl: RTL and testbench

- Sequencing controller that wraps an enable counter.
- Accepts a start command with a terminal count and a repeat count, then runs the counter through the programmed passes.
- Supports pause and abort; reports per-pass wrap ticks and a final done pulse.
- Sits between a host/control FSM and any datapath needing timed phases (delays, frame timing, repeated bursts).

---
 rtl/counter_ctrl_pkg.sv | 27 ++
 rtl/counter_ctrl_if.sv | 36 +++
 rtl/counter_ctrl_count_en.sv | 39 +++
 rtl/counter_ctrl.sv | 137 +++++++++++++
 tb/tb_counter_ctrl.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/counter_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// counter_ctrl_pkg
// Shared definitions for the counter sequencing controller: default widths,
// the controller state encoding and a small state-decode helper.
// No ports (package).
// ---------------------------------------------------------------------------
package counter_ctrl_pkg;

    // Default width of the counter and of the terminal count
    localparam int DEF_BITS      = 4;
    // Default width of the repeat count and of the pass index
    localparam int DEF_REPS_BITS = 3;

    // Controller states, 2-bit encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } ctrl_state_t;

    // A run is in progress while the controller is counting or paused
    function automatic logic isBusyState(input ctrl_state_t s);
        return (s == RUN) || (s == HOLD);
    endfunction

endpackage

// File: rtl/counter_ctrl_if.sv
// ---------------------------------------------------------------------------
// counter_ctrl_if
// Command/status bundle between a host and the counter sequencing controller.
//   Host -> controller : start, stop, pause, limit, reps
//   Controller -> host : count, rep_idx, busy, tick, done
// Modports: master (host side), slave (controller side).
// ---------------------------------------------------------------------------
interface counter_ctrl_if
    import counter_ctrl_pkg::*;
#(
    parameter int BITS      = DEF_BITS,
    parameter int REPS_BITS = DEF_REPS_BITS
) ();

    logic                 start;
    logic                 stop;
    logic                 pause;
    logic [BITS-1:0]      limit;
    logic [REPS_BITS-1:0] reps;
    logic [BITS-1:0]      count;
    logic [REPS_BITS-1:0] rep_idx;
    logic                 busy;
    logic                 tick;
    logic                 done;

    modport master (
        output start, stop, pause, limit, reps,
        input  count, rep_idx, busy, tick, done
    );

    modport slave (
        input  start, stop, pause, limit, reps,
        output count, rep_idx, busy, tick, done
    );

endinterface

// File: rtl/counter_ctrl_count_en.sv
// ---------------------------------------------------------------------------
// count_en
// BITS-wide up counter with synchronous clear and count enable.
// Ports:
//   clk      rising-edge clock
//   r        synchronous active-high reset
//   i_clr    synchronous clear, wins over i_en
//   i_en     count enable
//   o_count  registered counter value
// ---------------------------------------------------------------------------
module count_en
    import counter_ctrl_pkg::*;
#(
    parameter int BITS = DEF_BITS
) (
    input  logic            clk,
    input  logic            r,
    input  logic            i_clr,
    input  logic            i_en,
    output logic [BITS-1:0] o_count
);

    logic [BITS-1:0] r_count;

    // Counter register: reset, then clear, then increment.
    // Wrapping is never relied on; the controller clears on its terminal compare.
    always_ff @(posedge clk) begin
        if (r) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/counter_ctrl.sv
// ---------------------------------------------------------------------------
// counter_ctrl
// Sequencing controller around an enable counter. A start in IDLE latches a
// terminal count and a repeat count; the counter then runs 0..limit for
// reps+1 passes. Pause freezes counting, stop aborts the run. A tick pulse
// marks each completed pass and a done pulse marks the end of the last one.
// Ports:
//   clk   rising-edge clock
//   r     synchronous active-high reset
//   bus   counter_ctrl_if.slave (start/stop/pause/limit/reps in,
//         count/rep_idx/busy/tick/done out, all outputs registered)
// ---------------------------------------------------------------------------
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int BITS      = DEF_BITS,
    parameter int REPS_BITS = DEF_REPS_BITS
) (
    input  logic          clk,
    input  logic          r,
    counter_ctrl_if.slave bus
);

    ctrl_state_t          r_state;
    ctrl_state_t          w_nextState;
    logic [BITS-1:0]      r_limitQ;
    logic [REPS_BITS-1:0] r_repsQ;
    logic [REPS_BITS-1:0] r_repIdx;
    logic                 r_busy;
    logic                 r_tick;
    logic                 r_done;

    logic                 w_accept;
    logic                 w_abort;
    logic                 w_running;
    logic                 w_terminal;
    logic                 w_lastPass;
    logic [BITS-1:0]      w_count;

    // Next-state and per-edge event decode. Priority is stop > pause > count.
    // HOLD counts on the same edge that sees pause low again, so every
    // paused edge costs exactly one cycle of run time.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_abort     = 1'b0;
        w_running   = 1'b0;
        w_terminal  = 1'b0;
        w_lastPass  = (r_repIdx == r_repsQ);
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_nextState = RUN;
                end
            end
            RUN, HOLD: begin
                if (bus.stop) begin
                    w_abort     = 1'b1;
                    w_nextState = IDLE;
                end else if (bus.pause) begin
                    w_nextState = HOLD;
                end else begin
                    w_running   = 1'b1;
                    w_nextState = RUN;
                    if (w_count == r_limitQ) begin
                        w_terminal = 1'b1;
                        if (w_lastPass) begin
                            w_nextState = DONE;
                        end
                    end
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (r) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Latched command, pass index and registered status pulses.
    // tick follows every terminal edge, so it lines up with count=0 of the
    // next pass or with done on the last pass; an abort never reaches here
    // as a terminal because stop outranks counting.
    always_ff @(posedge clk) begin
        if (r) begin
            r_limitQ <= '0;
            r_repsQ  <= '0;
            r_repIdx <= '0;
            r_busy   <= 1'b0;
            r_tick   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_tick <= w_terminal;
            r_done <= (w_nextState == DONE);
            r_busy <= isBusyState(w_nextState);
            if (w_accept) begin
                r_limitQ <= bus.limit;
                r_repsQ  <= bus.reps;
                r_repIdx <= '0;
            end else if (w_abort) begin
                r_repIdx <= '0;
            end else if (w_terminal && !w_lastPass) begin
                r_repIdx <= r_repIdx + 1'b1;
            end
        end
    end

    // Counter clears on a new command, at the end of each pass and on abort
    count_en #(
        .BITS (BITS)
    ) u_countEn (
        .clk     (clk),
        .r       (r),
        .i_clr   (w_accept | w_terminal | w_abort),
        .i_en    (w_running),
        .o_count (w_count)
    );

    assign bus.count   = w_count;
    assign bus.rep_idx = r_repIdx;
    assign bus.busy    = r_busy;
    assign bus.tick    = r_tick;
    assign bus.done    = r_done;

endmodule

// File: tb/tb_counter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_counter_ctrl
// Directed self-checking bench for counter_ctrl. "Cycle n" is the cycle
// following the n-th rising edge after the edge that sampled start; outputs
// are sampled 1 time unit after each rising edge and inputs are changed at
// that same point so they are stable for the next edge.
// ---------------------------------------------------------------------------
module tb_counter_ctrl;
    import counter_ctrl_pkg::*;

    localparam int BITS      = DEF_BITS;
    localparam int REPS_BITS = DEF_REPS_BITS;

    logic clk = 1'b0;
    logic r   = 1'b1;
    int   compareCount  = 0;
    int   mismatchCount = 0;

    counter_ctrl_if #(.BITS(BITS), .REPS_BITS(REPS_BITS)) ctrlBus ();

    counter_ctrl #(.BITS(BITS), .REPS_BITS(REPS_BITS)) dut (
        .clk (clk),
        .r   (r),
        .bus (ctrlBus)
    );

    // 10-unit clock period
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Checks every status output for one cycle
    task automatic checkAll(input string tag, input int c, input int eCount,
                            input int eRep, input int eBusy, input int eTick,
                            input int eDone);
        checkOutput($sformatf("%s c%0d count", tag, c), 32'(ctrlBus.count), eCount);
        checkOutput($sformatf("%s c%0d rep_idx", tag, c), 32'(ctrlBus.rep_idx), eRep);
        checkOutput($sformatf("%s c%0d busy", tag, c), 32'(ctrlBus.busy), eBusy);
        checkOutput($sformatf("%s c%0d tick", tag, c), 32'(ctrlBus.tick), eTick);
        checkOutput($sformatf("%s c%0d done", tag, c), 32'(ctrlBus.done), eDone);
    endtask

    // Drives the host-side command inputs
    task automatic applyStimulus(input logic s, input logic st, input logic p,
                                 input logic [BITS-1:0] lim,
                                 input logic [REPS_BITS-1:0] rp);
        ctrlBus.start = s;
        ctrlBus.stop  = st;
        ctrlBus.pause = p;
        ctrlBus.limit = lim;
        ctrlBus.reps  = rp;
    endtask

    // Advances to just after the next rising edge
    task automatic tickClock();
        @(posedge clk);
        #1;
    endtask

    task automatic idleGap();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        tickClock();
        tickClock();
    endtask

    initial begin
        // Reset held for two edges while the inputs toggle randomly
        r = 1'b1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'($urandom), 1'($urandom), 1'($urandom),
                          BITS'($urandom), REPS_BITS'($urandom));
            tickClock();
        end
        checkAll("reset", 0, 0, 0, 0, 0, 0);
        r = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        tickClock();
        checkAll("postReset", 0, 0, 0, 0, 0, 0);

        // Basic run: limit=3, reps=1, done at cycle 9
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd3, 3'd1);
        tickClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd3, 3'd1);
        for (int c = 1; c <= 10; c++) begin
            checkAll("basic", c, (c <= 8) ? (c - 1) % 4 : 0, (c <= 4) ? 0 : 1,
                     int'(c <= 8), int'(c == 5 || c == 9), int'(c == 9));
            tickClock();
        end
        idleGap();

        // Pause on edges 3 and 4 while count=2: done moves from 7 to 9
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd5, 3'd0);
        tickClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd5, 3'd0);
        for (int c = 1; c <= 10; c++) begin
            checkAll("pause", c,
                     (c <= 3) ? c - 1 : (c <= 5) ? 2 : (c <= 8) ? c - 3 : 0,
                     0, int'(c <= 8), int'(c == 9), int'(c == 9));
            ctrlBus.pause = (c == 3 || c == 4);
            tickClock();
        end
        idleGap();

        // Abort at count=4; a start with limit=2 while busy is ignored
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd9, 3'd0);
        tickClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd9, 3'd0);
        for (int c = 1; c <= 7; c++) begin
            checkAll("abort", c, (c <= 5) ? c - 1 : 0, 0, int'(c <= 5), 0, 0);
            if (c == 2) begin
                applyStimulus(1'b1, 1'b0, 1'b0, 4'd2, 3'd0);
            end else if (c == 5) begin
                applyStimulus(1'b0, 1'b1, 1'b0, 4'd9, 3'd0);
            end else begin
                applyStimulus(1'b0, 1'b0, 1'b0, 4'd9, 3'd0);
            end
            tickClock();
        end
        idleGap();

        // limit=0, reps=2: one-cycle passes, ticks at 2,3,4, done at 4
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 3'd2);
        tickClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 3'd2);
        for (int c = 1; c <= 5; c++) begin
            checkAll("limit0", c, 0, (c <= 3) ? c - 1 : 2, int'(c <= 3),
                     int'(c >= 2 && c <= 4), int'(c == 4));
            tickClock();
        end
        idleGap();

        // Full range: limit=15 returns to 0 by compare, done at 17
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd15, 3'd0);
        tickClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd15, 3'd0);
        for (int c = 1; c <= 18; c++) begin
            checkAll("full", c, (c <= 16) ? c - 1 : 0, 0, int'(c <= 16),
                     int'(c == 17), int'(c == 17));
            tickClock();
        end
        idleGap();

        // Reset mid-run at count=7 clears everything with no done
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd15, 3'd1);
        tickClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd15, 3'd1);
        for (int c = 1; c <= 8; c++) begin
            checkAll("preReset", c, c - 1, 0, 1, 0, 0);
            if (c < 8) tickClock();
        end
        r = 1'b1;
        tickClock();
        r = 1'b0;
        checkAll("midReset", 9, 0, 0, 0, 0, 0);
        tickClock();
        checkAll("midReset", 10, 0, 0, 0, 0, 0);

        // Reset and start on the same edge: reset wins, stays IDLE
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd5, 3'd0);
        r = 1'b1;
        tickClock();
        r = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd5, 3'd0);
        checkAll("resetStart", 1, 0, 0, 0, 0, 0);
        tickClock();
        checkAll("resetStart", 2, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
